ram_arbiter_2p: RTL and testbench
=================================

Name: ram_arbiter_2p

Overview:
Two-requester round-robin arbiter and sequencer in front of the single-port synchronous block RAM (ip_ram, one-cycle read latency).
- Accepts read/write requests from two masters with a valid/grant handshake.
- Issues at most one RAM access per cycle from registered RAM-side outputs.
- Routes each read's data back to the requester that issued it.

Parameters:
- ADDR_W, 5, RAM address width (32 words).
- DATA_W, 8, RAM data width.

Ports:
- sys_clk  in  1  system clock, all logic on rising edge
- sys_rst_n  in  1  asynchronous, active-low reset
- req  in  2  request valid per requester (bit i = requester i)
- we  in  2  1 = write, 0 = read, per requester
- addr  in  2*ADDR_W  request address; requester i at [i*ADDR_W +: ADDR_W]
- wdata  in  2*DATA_W  write data; requester i at [i*DATA_W +: DATA_W]
- gnt  out  2  combinational accept; transfer occurs at the edge where req[i]&gnt[i]
- rvalid  out  2  one-cycle read-return strobe per requester
- rdata  out  2*DATA_W  read data per requester, valid when rvalid[i]
- ram_en  out  1  RAM access enable (registered)
- ram_we  out  1  RAM write enable (registered)
- ram_addr  out  ADDR_W  RAM address (registered)
- ram_wdata  out  DATA_W  RAM write data (registered)
- ram_rdata  in  DATA_W  RAM read data, valid the cycle after the RAM samples ram_en with ram_we=0

Behaviour:
- Reset (async, sys_rst_n=0): ram_en=0, ram_we=0, ram_addr=0, ram_wdata=0, rvalid=0, rdata=0, last=1 (requester 0 wins the first tie), read-tracking pipeline cleared. gnt is 0 while reset is asserted.
- Arbitration (combinational):
  - Only req[0]: gnt=01. Only req[1]: gnt=10. Neither: gnt=00.
  - Both: grant the requester not equal to last.
  - gnt is one-hot or zero, never 11.
- Handshake: a requester holds req/we/addr/wdata stable until it sees gnt high at a clock edge. It may present a new request in the very next cycle, so back-to-back transfers are allowed.
- last updates only on an accepted transfer (req&gnt). It is unchanged in idle cycles.
- Fairness: a continuously asserted request waits at most one transfer of the other requester. Two saturating requesters alternate 0,1,0,1…
- Accept at edge k:
  - In cycle k+1, ram_en=1, ram_we=we[i], ram_addr=addr[i], ram_wdata=wdata[i].
  - With no accept at edge k, ram_en=0 and ram_we=0 in cycle k+1; ram_addr and ram_wdata hold their previous values.
- Write: completes at edge k+1 (RAM samples it there). No response is generated.
- Read:
  - RAM samples at edge k+1; ram_rdata is valid in cycle k+2.
  - The arbiter registers the data at edge k+2, so rvalid[i]=1 and rdata[i]=data for exactly one cycle after edge k+2.
  - Total read latency: 2 cycles after the accepting edge.
  - rdata[i] holds its last value when rvalid[i]=0.
- Read tracking: 2-stage shift pipeline of {valid, is_read, id}. Returns for interleaved requesters stay in issue order and are never misrouted. Up to two reads can be in flight.
- Ordering: accesses reach the RAM in acceptance order. A read accepted one cycle after a write to the same address returns the new data.
- Single port: no simultaneous RAM read and write. Throughput is 1 access/cycle.
- Reset mid-operation: all in-flight reads are dropped with no rvalid. The first request after reset release follows the post-reset tie rule.
- Width rules: addresses and data pass through unmodified; there is no address wrap logic in the arbiter.

Test Plan:
- Reset: hold sys_rst_n=0 for 7 ns with req=11 -> gnt=00, ram_en=0, rvalid=00. After release, the first tie grants requester 0 (gnt=01).
- Single write/read: requester 0 writes 0xA5 to addr 3. In the next cycle requester 0 reads addr 3 -> ram_en/ram_we=1/1 then 1/0. rvalid[0]=1 with rdata[0]=0xA5 exactly 2 cycles after the read accept; rvalid[1] stays 0.
- Round robin saturation: both requesters hold req for 8 transfers -> gnt alternates 01,10,01,… Each requester gets 4 accepts, with no gap cycles on ram_en.
- Interleaved reads: pre-load addr 0=0x11 and addr 1=0x22. Requester 0 reads addr 0 and requester 1 reads addr 1 back-to-back -> rvalid=01 with rdata[0]=0x11, then next cycle rvalid=10 with rdata[1]=0x22.
- Cross-requester coherence: requester 1 writes 0x5C to addr 31, then requester 0 reads addr 31 in the following cycle -> rdata[0]=0x5C.
- Reset mid-read: accept a read, then assert sys_rst_n=0 one cycle later -> no rvalid pulse ever appears. After release, a read of the same address returns the stored RAM value.

Source files
------------

// File: rtl/ram_arbiter_2p.sv
// Two-requester round-robin arbiter in front of a single-port synchronous RAM.
// Issues one registered RAM access per cycle and routes read data back to its issuer.
module ram_arbiter_2p #(
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DATA_W = 8
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst_n,
    input  logic [1:0]            req,
    input  logic [1:0]            we,
    input  logic [2*ADDR_W-1:0]   addr,
    input  logic [2*DATA_W-1:0]   wdata,
    output logic [1:0]            gnt,
    output logic [1:0]            rvalid,
    output logic [2*DATA_W-1:0]   rdata,
    output logic                  ram_en,
    output logic                  ram_we,
    output logic [ADDR_W-1:0]     ram_addr,
    output logic [DATA_W-1:0]     ram_wdata,
    input  logic [DATA_W-1:0]     ram_rdata
);

    typedef struct packed {
        logic valid;
        logic is_read;
        logic id;
    } rd_tag_t;

    logic                  last_q, last_d;
    logic                  ram_en_q, ram_en_d;
    logic                  ram_we_q, ram_we_d;
    logic [ADDR_W-1:0]     ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0]     ram_wdata_q, ram_wdata_d;
    rd_tag_t               tag0_q, tag0_d;
    rd_tag_t               tag1_q, tag1_d;
    logic [1:0]            rvalid_q, rvalid_d;
    logic [2*DATA_W-1:0]   rdata_q, rdata_d;
    logic                  accept;
    logic                  sel;

    // Grant: single requester wins outright, a tie goes to the one not served last.
    always_comb begin
        gnt = 2'b00;
        if (sys_rst_n) begin
            case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = last_q ? 2'b01 : 2'b10;
                default: gnt = 2'b00;
            endcase
        end
    end

    assign accept = |(req & gnt);
    assign sel    = gnt[1];

    always_comb begin
        last_d      = last_q;
        ram_en_d    = 1'b0;
        ram_we_d    = 1'b0;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        tag0_d      = '{valid: accept, is_read: accept & ~we[sel], id: sel};
        tag1_d      = tag0_q;
        rvalid_d    = 2'b00;
        rdata_d     = rdata_q;
        if (accept) begin
            last_d      = sel;
            ram_en_d    = 1'b1;
            ram_we_d    = we[sel];
            ram_addr_d  = sel ? addr[2*ADDR_W-1:ADDR_W] : addr[ADDR_W-1:0];
            ram_wdata_d = sel ? wdata[2*DATA_W-1:DATA_W] : wdata[DATA_W-1:0];
        end
        // tag1 lines up with the cycle in which ram_rdata holds that read's data
        if (tag1_q.valid && tag1_q.is_read) begin
            if (tag1_q.id) begin
                rvalid_d[1]                = 1'b1;
                rdata_d[2*DATA_W-1:DATA_W] = ram_rdata;
            end else begin
                rvalid_d[0]          = 1'b1;
                rdata_d[DATA_W-1:0]  = ram_rdata;
            end
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            last_q      <= 1'b1;
            ram_en_q    <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            tag0_q      <= '0;
            tag1_q      <= '0;
            rvalid_q    <= 2'b00;
            rdata_q     <= '0;
        end else begin
            last_q      <= last_d;
            ram_en_q    <= ram_en_d;
            ram_we_q    <= ram_we_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            tag0_q      <= tag0_d;
            tag1_q      <= tag1_d;
            rvalid_q    <= rvalid_d;
            rdata_q     <= rdata_d;
        end
    end

    assign ram_en    = ram_en_q;
    assign ram_we    = ram_we_q;
    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;
    assign rvalid    = rvalid_q;
    assign rdata     = rdata_q;

endmodule

// File: tb/tb_ram_arbiter_2p.sv
// Directed bench for ram_arbiter_2p with a behavioural one-cycle-latency RAM.
// Inputs change on the falling edge; outputs are sampled there too.
module tb_ram_arbiter_2p;

    localparam int unsigned ADDR_W = 5;
    localparam int unsigned DATA_W = 8;

    logic                  sys_clk;
    logic                  sys_rst_n;
    logic [1:0]            req;
    logic [1:0]            we;
    logic [2*ADDR_W-1:0]   addr;
    logic [2*DATA_W-1:0]   wdata;
    logic [1:0]            gnt;
    logic [1:0]            rvalid;
    logic [2*DATA_W-1:0]   rdata;
    logic                  ram_en;
    logic                  ram_we;
    logic [ADDR_W-1:0]     ram_addr;
    logic [DATA_W-1:0]     ram_wdata;
    logic [DATA_W-1:0]     ram_rdata;

    logic [DATA_W-1:0]     mem [32];

    int n_tests;
    int n_fail;

    ram_arbiter_2p #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .req       (req),
        .we        (we),
        .addr      (addr),
        .wdata     (wdata),
        .gnt       (gnt),
        .rvalid    (rvalid),
        .rdata     (rdata),
        .ram_en    (ram_en),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    // Single-port synchronous RAM, one-cycle read latency, contents survive reset.
    always @(posedge sys_clk) begin
        if (ram_en) begin
            if (ram_we) mem[ram_addr] <= ram_wdata;
            else        ram_rdata     <= mem[ram_addr];
        end
    end

    task automatic test_reset();
        sys_rst_n = 1'b0;
        req = 2'b11; we = 2'b00; addr = '0; wdata = '0;
        #7;
        n_tests++;
        if (gnt !== 2'b00) begin n_fail++; $display("FAIL reset_gnt: got %b expected 00", gnt); end
        n_tests++;
        if (ram_en !== 1'b0) begin n_fail++; $display("FAIL reset_ram_en: got %b expected 0", ram_en); end
        n_tests++;
        if (rvalid !== 2'b00) begin n_fail++; $display("FAIL reset_rvalid: got %b expected 00", rvalid); end
        sys_rst_n = 1'b1;
        #1;
        n_tests++;
        if (gnt !== 2'b01) begin n_fail++; $display("FAIL reset_first_tie: got %b expected 01", gnt); end
        req = 2'b00;
    endtask

    task automatic test_single_wr_rd();
        @(negedge sys_clk);
        req = 2'b01; we = 2'b01; addr[4:0] = 5'd3; wdata[7:0] = 8'hA5;
        #1;
        n_tests++;
        if (gnt !== 2'b01) begin n_fail++; $display("FAIL single_wr_gnt: got %b expected 01", gnt); end
        @(negedge sys_clk);
        n_tests++;
        if ({ram_en, ram_we, ram_addr, ram_wdata} !== {1'b1, 1'b1, 5'd3, 8'hA5}) begin
            n_fail++;
            $display("FAIL single_wr_ram: got en=%b we=%b a=%0d d=%h expected 1 1 3 a5", ram_en, ram_we, ram_addr, ram_wdata);
        end
        we = 2'b00;
        @(negedge sys_clk);
        n_tests++;
        if ({ram_en, ram_we, ram_addr} !== {1'b1, 1'b0, 5'd3}) begin
            n_fail++;
            $display("FAIL single_rd_ram: got en=%b we=%b a=%0d expected 1 0 3", ram_en, ram_we, ram_addr);
        end
        req = 2'b00;
        @(negedge sys_clk);
        n_tests++;
        if (ram_en !== 1'b0 || rvalid !== 2'b00) begin
            n_fail++;
            $display("FAIL single_rd_early: got en=%b rvalid=%b expected 0 00", ram_en, rvalid);
        end
        @(negedge sys_clk);
        n_tests++;
        if (rvalid !== 2'b01 || rdata[7:0] !== 8'hA5) begin
            n_fail++;
            $display("FAIL single_rd_data: got rvalid=%b rdata0=%h expected 01 a5", rvalid, rdata[7:0]);
        end
        @(negedge sys_clk);
        n_tests++;
        if (rvalid !== 2'b00 || rdata[7:0] !== 8'hA5) begin
            n_fail++;
            $display("FAIL single_rd_hold: got rvalid=%b rdata0=%h expected 00 a5", rvalid, rdata[7:0]);
        end
    endtask

    task automatic test_round_robin();
        int n0;
        int n1;
        logic [1:0] exp_g;
        logic [4:0] exp_a;
        n0 = 0; n1 = 0;
        @(negedge sys_clk);
        sys_rst_n = 1'b0; req = 2'b00;
        #1;
        sys_rst_n = 1'b1;
        req = 2'b11; we = 2'b11;
        addr = {5'd16, 5'd8}; wdata = {8'h90, 8'h80};
        for (int i = 0; i < 8; i++) begin
            #1;
            exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
            n_tests++;
            if (gnt !== exp_g) begin n_fail++; $display("FAIL rr_gnt[%0d]: got %b expected %b", i, gnt, exp_g); end
            @(negedge sys_clk);
            exp_a = (i % 2 == 0) ? 5'(8 + n0) : 5'(16 + n1);
            n_tests++;
            if (ram_en !== 1'b1 || ram_addr !== exp_a) begin
                n_fail++;
                $display("FAIL rr_ram[%0d]: got en=%b a=%0d expected 1 %0d", i, ram_en, ram_addr, exp_a);
            end
            if (i % 2 == 0) begin
                n0++; addr[4:0] = 5'(8 + n0); wdata[7:0] = 8'(8'h80 + n0);
            end else begin
                n1++; addr[9:5] = 5'(16 + n1); wdata[15:8] = 8'(8'h90 + n1);
            end
        end
        req = 2'b00;
        @(negedge sys_clk);
        n_tests++;
        if (ram_en !== 1'b0) begin n_fail++; $display("FAIL rr_idle: got en=%b expected 0", ram_en); end
    endtask

    task automatic test_interleaved_reads();
        @(negedge sys_clk);
        req = 2'b01; we = 2'b01; addr[4:0] = 5'd0; wdata[7:0] = 8'h11;
        @(negedge sys_clk);
        addr[4:0] = 5'd1; wdata[7:0] = 8'h22;
        @(negedge sys_clk);
        we = 2'b00; addr[4:0] = 5'd0;
        #1;
        n_tests++;
        if (gnt !== 2'b01) begin n_fail++; $display("FAIL il_gnt0: got %b expected 01", gnt); end
        @(negedge sys_clk);
        req = 2'b10; addr[9:5] = 5'd1;
        #1;
        n_tests++;
        if (gnt !== 2'b10) begin n_fail++; $display("FAIL il_gnt1: got %b expected 10", gnt); end
        @(negedge sys_clk);
        req = 2'b00;
        @(negedge sys_clk);
        n_tests++;
        if (rvalid !== 2'b01 || rdata[7:0] !== 8'h11) begin
            n_fail++;
            $display("FAIL il_ret0: got rvalid=%b rdata0=%h expected 01 11", rvalid, rdata[7:0]);
        end
        @(negedge sys_clk);
        n_tests++;
        if (rvalid !== 2'b10 || rdata[15:8] !== 8'h22 || rdata[7:0] !== 8'h11) begin
            n_fail++;
            $display("FAIL il_ret1: got rvalid=%b rdata=%h expected 10 2211", rvalid, rdata);
        end
    endtask

    task automatic test_coherence();
        @(negedge sys_clk);
        req = 2'b10; we = 2'b10; addr[9:5] = 5'd31; wdata[15:8] = 8'h5C;
        @(negedge sys_clk);
        req = 2'b01; we = 2'b00; addr[4:0] = 5'd31;
        @(negedge sys_clk);
        req = 2'b00;
        @(negedge sys_clk);
        @(negedge sys_clk);
        n_tests++;
        if (rvalid !== 2'b01 || rdata[7:0] !== 8'h5C) begin
            n_fail++;
            $display("FAIL coh_ret: got rvalid=%b rdata0=%h expected 01 5c", rvalid, rdata[7:0]);
        end
    endtask

    task automatic test_reset_mid_read();
        @(negedge sys_clk);
        req = 2'b01; we = 2'b00; addr[4:0] = 5'd31;
        @(negedge sys_clk);
        req = 2'b00;
        sys_rst_n = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge sys_clk);
            if (i == 1) sys_rst_n = 1'b1;
            n_tests++;
            if (rvalid !== 2'b00) begin n_fail++; $display("FAIL rst_mid_rvalid[%0d]: got %b expected 00", i, rvalid); end
        end
        req = 2'b11; we = 2'b00; addr = {5'd3, 5'd31};
        #1;
        n_tests++;
        if (gnt !== 2'b01) begin n_fail++; $display("FAIL rst_mid_tie: got %b expected 01", gnt); end
        @(negedge sys_clk);
        req = 2'b10;
        #1;
        n_tests++;
        if (gnt !== 2'b10) begin n_fail++; $display("FAIL rst_mid_gnt1: got %b expected 10", gnt); end
        @(negedge sys_clk);
        req = 2'b00;
        @(negedge sys_clk);
        n_tests++;
        if (rvalid !== 2'b01 || rdata[7:0] !== 8'h5C) begin
            n_fail++;
            $display("FAIL rst_mid_ret0: got rvalid=%b rdata0=%h expected 01 5c", rvalid, rdata[7:0]);
        end
        @(negedge sys_clk);
        n_tests++;
        if (rvalid !== 2'b10 || rdata[15:8] !== 8'hA5) begin
            n_fail++;
            $display("FAIL rst_mid_ret1: got rvalid=%b rdata1=%h expected 10 a5", rvalid, rdata[15:8]);
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        test_reset();
        test_single_wr_rd();
        test_round_robin();
        test_interleaved_reads();
        test_coherence();
        test_reset_mid_read();
        repeat (2) @(negedge sys_clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
